// File: rtl/window_fetch_sequencer_if.sv
// rtl/window_fetch_sequencer_if.sv - fetch address handshake and window position bundle
interface window_fetch_sequencer_if;
  logic [31:0] addr;
  logic        addr_valid;
  logic        addr_ready;
  logic        win_first;
  logic        win_last;
  logic [15:0] win_x;
  logic [15:0] win_y;

  modport master (
    output addr, addr_valid, win_first, win_last, win_x, win_y,
    input  addr_ready
  );

  modport slave (
    input  addr, addr_valid, win_first, win_last, win_x, win_y,
    output addr_ready
  );
endinterface

// File: rtl/window_fetch_sequencer.sv
// rtl/window_fetch_sequencer.sv - 4x4 target-window address walker; WFS_ROW_STRIDE_EN selects 2-D row-stride offsets
module window_fetch_sequencer #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic [31:0]                      frame_base,
  output logic                             busy,
  output logic                             frame_done,
  window_fetch_sequencer_if.master         fetch
);

  typedef enum logic [1:0] {IDLE, ISSUE, NEXT, DONE} state_t;

  localparam logic [15:0] X_LAST = 16'(FRAME_W - 4);
  localparam logic [15:0] Y_LAST = 16'(FRAME_H - 4);

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic [31:0] base_q, base_d;
  logic [31:0] win_base, offset;
  logic        issuing;

  assign issuing = (state_q == ISSUE);

  always_comb begin
    win_base = base_q + ((32'(y_q) * 32'(FRAME_W) + 32'(x_q)) << 2);
`ifdef WFS_ROW_STRIDE_EN
    offset = (32'(k_q[3:2]) * 32'(FRAME_W) + 32'(k_q[1:0])) << 2;
`else
    offset = 32'(k_q) << 2;
`endif
  end

  // Outputs derive only from registered state, so they stay stable under backpressure.
  assign fetch.addr_valid = issuing;
  assign fetch.addr       = issuing ? (win_base + offset) : 32'd0;
  assign fetch.win_first  = issuing && (k_q == 4'd0);
  assign fetch.win_last   = issuing && (k_q == 4'd15);
  assign fetch.win_x      = x_q;
  assign fetch.win_y      = y_q;
  assign busy             = (state_q != IDLE);
  assign frame_done       = (state_q == DONE) && !abort;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= 4'd0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      base_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = frame_base;
          x_d     = 16'd0;
          y_d     = 16'd0;
          k_d     = 4'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Abort wins over a coincident handshake; that beat is dropped from the count.
        if (abort) begin
          k_d     = 4'd0;
          state_d = IDLE;
        end else if (fetch.addr_ready) begin
          k_d = k_q + 4'd1;
          if (k_q == 4'd15) state_d = NEXT;
        end
      end
      NEXT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (x_q == X_LAST && y_q == Y_LAST) begin
          state_d = DONE;
        end else begin
          if (x_q < X_LAST) begin
            x_d = x_q + 16'd1;
          end else begin
            x_d = 16'd0;
            y_d = y_q + 16'd1;
          end
          state_d = ISSUE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_window_fetch_sequencer.sv
// tb/tb_window_fetch_sequencer.sv - vector table, corner sequences and random-backpressure scoreboard
module tb_window_fetch_sequencer;
  localparam int FW = 8;
  localparam int FH = 8;
`ifdef WFS_ROW_STRIDE_EN
  localparam bit STRIDE = 1'b1;
`else
  localparam bit STRIDE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start, abort, start4;
  logic [31:0] frame_base;
  logic        busy, frame_done, busy4, done4;

  window_fetch_sequencer_if fif();
  window_fetch_sequencer_if fif4();

  window_fetch_sequencer #(.FRAME_W(FW), .FRAME_H(FH)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .frame_base(frame_base),
    .busy(busy), .frame_done(frame_done), .fetch(fif)
  );

  window_fetch_sequencer #(.FRAME_W(4), .FRAME_H(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .abort(1'b0), .frame_base(32'h2000),
    .busy(busy4), .frame_done(done4), .fetch(fif4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc;

  typedef struct {
    int          cyc;
    logic [31:0] valid, addr, first, last, x, y, busy, done;
  } vec_t;

  typedef struct {
    logic [31:0] addr, first, last, x, y;
  } exp_t;

  vec_t tbl[$];
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] off(input int k, input int fw);
    if (STRIDE) return 32'(4 * ((k / 4) * fw + k % 4));
    else        return 32'(4 * k);
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] base, input int x, input int y,
                                           input int k, input int fw);
    return base + 32'(4 * (y * fw + x)) + off(k, fw);
  endfunction

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".valid"}, 32'(fif.addr_valid), v.valid);
    check({tag, ".addr"},  fif.addr, v.addr);
    check({tag, ".first"}, 32'(fif.win_first), v.first);
    check({tag, ".last"},  32'(fif.win_last), v.last);
    check({tag, ".x"},     32'(fif.win_x), v.x);
    check({tag, ".y"},     32'(fif.win_y), v.y);
    check({tag, ".busy"},  32'(busy), v.busy);
    check({tag, ".done"},  32'(frame_done), v.done);
  endtask

  task automatic random_frame(input logic [31:0] base);
    int last_hs = -100;
    bit seen = 1'b0;
    q.delete();
    for (int y = 0; y <= FH - 4; y++)
      for (int x = 0; x <= FW - 4; x++)
        for (int k = 0; k < 16; k++)
          q.push_back('{exp_addr(base, x, y, k, FW), 32'(k == 0), 32'(k == 15), 32'(x), 32'(y)});
    check("rand.count", 32'(q.size()), 32'((FW - 3) * (FH - 3) * 16));
    tick();
    frame_base = base;
    start = 1'b1;
    fif.addr_ready = 1'b0;
    for (int c = 1; c < 4000; c++) begin
      tick();
      if (fif.addr_valid) begin
        if (q.size() == 0) begin
          check("rand.extra_addr", 32'd1, 32'd0);
        end else begin
          check($sformatf("rand.addr c=%0d", c),  fif.addr, q[0].addr);
          check($sformatf("rand.first c=%0d", c), 32'(fif.win_first), q[0].first);
          check($sformatf("rand.last c=%0d", c),  32'(fif.win_last), q[0].last);
          check($sformatf("rand.x c=%0d", c),     32'(fif.win_x), q[0].x);
          check($sformatf("rand.y c=%0d", c),     32'(fif.win_y), q[0].y);
        end
      end
      if (frame_done) begin
        check("rand.remaining", 32'(q.size()), 32'd0);
        check("rand.done_latency", 32'(c - last_hs), 32'd2);
        seen = 1'b1;
        break;
      end
      fif.addr_ready = ($urandom % 3) != 0;
      start = ($urandom % 4) == 0;
      if (fif.addr_valid && fif.addr_ready && q.size() > 0) begin
        void'(q.pop_front());
        if (q.size() == 0) last_hs = c;
      end
    end
    start = 1'b0;
    fif.addr_ready = 1'b0;
    if (!seen) check("rand.timeout", 32'd1, 32'd0);
    tick();
    check("rand.idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; start4 = 1'b0;
    frame_base = 32'd0; fif.addr_ready = 1'b0; fif4.addr_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_outputs("reset", '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    check("reset.busy4", 32'(busy4), 32'd0);

    // Full linear-ready scan against a cycle-stamped vector table
    tbl.push_back('{0,   0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{1,   1, 32'h1000, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{2,   1, 32'h1004, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{5,   1, STRIDE ? 32'h1020 : 32'h1010, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{16,  1, STRIDE ? 32'h106C : 32'h103C, 0, 1, 0, 0, 1, 0});
    tbl.push_back('{17,  0, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{18,  1, 32'h1004, 1, 0, 1, 0, 1, 0});
    tbl.push_back('{86,  1, 32'h1020, 1, 0, 0, 1, 1, 0});
    tbl.push_back('{409, 1, 32'h1090, 1, 0, 4, 4, 1, 0});
    tbl.push_back('{424, 1, STRIDE ? 32'h10FC : 32'h10CC, 0, 1, 4, 4, 1, 0});
    tbl.push_back('{425, 0, 0, 0, 0, 4, 4, 1, 0});
    tbl.push_back('{426, 0, 0, 0, 0, 4, 4, 1, 1});
    tbl.push_back('{427, 0, 0, 0, 0, 4, 4, 0, 0});
    cyc = 0;
    start = 1'b1; frame_base = 32'h1000; fif.addr_ready = 1'b1;
    foreach (tbl[i]) begin
      while (cyc < tbl[i].cyc) begin
        tick();
        cyc++;
        start = 1'b0;
      end
      check_outputs($sformatf("vec%0d", i), tbl[i]);
    end

    // Backpressure: ready low for 3 cycles at k=5
    tick();
    start = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      start = 1'b0;
      if (c == 6) fif.addr_ready = 1'b0;
      if (c == 9) fif.addr_ready = 1'b1;
      if (c >= 6 && c <= 9) check($sformatf("bp.hold c=%0d", c), fif.addr, 32'h1000 + off(5, FW));
      if (c == 20) check("bp.bubble", 32'(fif.addr_valid), 32'd0);
      if (c == 21) begin
        check("bp.next_first", 32'(fif.win_first), 32'd1);
        check("bp.next_addr", fif.addr, 32'h1004);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("bp.abort_busy", 32'(busy), 32'd0);

    // Abort in the third window at k=7, then restart from origin
    start = 1'b1;
    for (int c = 1; c <= 42; c++) begin
      tick();
      start = 1'b0;
    end
    check("abort.pre_addr", fif.addr, exp_addr(32'h1000, 2, 0, 7, FW));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort.valid", 32'(fif.addr_valid), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("abort.no_done", 32'(frame_done), 32'd0);
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart.x", 32'(fif.win_x), 32'd0);
    check("restart.addr", fif.addr, 32'h1000);
    check("restart.first", 32'(fif.win_first), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Reset in the tenth window clears every output
    start = 1'b1;
    for (int c = 1; c <= 157; c++) begin
      tick();
      start = 1'b0;
    end
    check("rst.pre_x", 32'(fif.win_x), 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_outputs("rst", '{0, 0, 0, 0, 0, 0, 0, 0, 0});

    // Minimum 4x4 frame: one window, done at cycle 18
    begin
      int hs = 0;
      start4 = 1'b1;
      for (int c = 1; c <= 19; c++) begin
        tick();
        start4 = 1'b0;
        if (fif4.addr_valid && fif4.addr_ready) begin
          check($sformatf("min.addr k=%0d", hs), fif4.addr, 32'h2000 + off(hs, 4));
          hs++;
        end
        check($sformatf("min.done c=%0d", c), 32'(done4), 32'(c == 18));
      end
      check("min.handshakes", 32'(hs), 32'd16);
      check("min.busy_end", 32'(busy4), 32'd0);
    end

    random_frame(32'h0000_4000);
    random_frame(32'hFFFF_FF40);
    random_frame($urandom & 32'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
